kfmmc_read_verify_sequencer: RTL and testbench
==============================================

# kfmmc_read_verify_sequencer

- Host-side sequencer that reads back a run of 512-byte blocks through the KFMMC drive's byte-wide register interface.
- Checks every byte against the incrementing pattern produced by the write sequencer, and reports pass/fail, mismatch count and progress.
- Sits beside the drive in the demo top level, in the position the write sequencer occupies, and is used after a write pass to prove the card contents.

## Interface
Parameters:
- BLOCK_COUNT, 8'h02: number of consecutive blocks read, starting at block 0.
- PATTERN_SEED, 8'h01: expected value of the first byte of block 0.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a run, accepted only in IDLE.
- data_bus  out  8  register write data to the drive.
- write_block_address_1..4  out  1 each  strobes for address bytes 0 (LSB) to 3.
- write_command  out  1  command strobe.
- read_data  out  1  byte-consume / interrupt-clear strobe.
- read_data_byte  in  8  byte presented by the drive.
- drive_busy  in  1  drive busy.
- read_byte_interrupt  in  1  byte available.
- read_completion_interrupt  in  1  block read finished.
- read_interface_error  in  1  drive-reported read failure.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  valid with done; 1 = no mismatch, no error.
- mismatch_count  out  16  saturating mismatch count.
- current_block  out  8  block under read.

## Operation
- IDLE: start moves the FSM to WAIT_READY and clears done, pass, mismatch_count, current_block and byte_index. The expected-byte register loads PATTERN_SEED.
- WAIT_READY: leave when ~drive_busy, then go to ADDR1.
- ADDR1..ADDR4: one cycle each.
  - ADDR1 drives data_bus=current_block with write_block_address_1=1.
  - ADDR2..ADDR4 drive data_bus=8'h00 with the matching strobe.
- START_READ: one cycle, data_bus=8'h80, write_command=1.
- WAIT_INTERRUPT: checks inputs in this priority order.
  - read_interface_error → FAIL.
  - read_completion_interrupt → CLEAR_COMPLETION.
  - read_byte_interrupt → ACCEPT_BYTE.
- ACCEPT_BYTE: one cycle, read_data=1.
  - read_data_byte is compared with the expected byte. A mismatch increments mismatch_count, saturating at 16'hFFFF.
  - The expected byte increments mod 256.
  - byte_index (10 bits) increments.
- WAIT_DEASSERT: wait for ~read_byte_interrupt, then return to WAIT_INTERRUPT. read_data is never held across consecutive cycles.
- CLEAR_COMPLETION: one cycle, read_data=1.
  - If byte_index ≠ 512, mismatch_count += 1 as a length fault.
  - byte_index is cleared.
- WAIT_BUSY: on ~drive_busy, one of two transitions.
  - current_block+1 == BLOCK_COUNT → DONE.
  - Otherwise current_block += 1 → WAIT_READY.
- DONE: done=1, pass=(mismatch_count==0); return to IDLE on the next start.
- FAIL: done=1, pass=0; return to IDLE on the next start.
- The expected pattern runs continuously across blocks and is not reseeded per block.
- All strobes and data_bus default to 0 outside the states named above.
- busy=1 in every state except IDLE, DONE and FAIL.
- start is ignored when not in IDLE, DONE or FAIL. In DONE/FAIL, start restarts the run exactly as from IDLE.

## Timing
- Reset values:
  - all strobes 0, data_bus 8'h00;
  - busy 0, done 0, pass 0;
  - mismatch_count 0, current_block 0;
  - FSM in IDLE.
- Reset mid-run aborts immediately; no strobe is issued afterwards.
- Start to first address strobe: 2 cycles when drive_busy is low (WAIT_READY, then ADDR1).
- Address and command sequence: 5 consecutive strobe cycles, ADDR1 through START_READ.
- Per byte: minimum 3 cycles (WAIT_INTERRUPT, ACCEPT_BYTE, WAIT_DEASSERT). Exactly one read_data pulse per byte.
- mismatch_count, pass and done update on the clock edge leaving the deciding state; they are visible the following cycle.
- Simultaneous read_byte_interrupt and read_completion_interrupt: completion wins.
- Simultaneous error and any other interrupt: error wins.

## Configuration
- Macro: KFMMC_READ_VERIFY_MISMATCH_LOG_EN.
- Defined: adds outputs first_mismatch_valid (1), first_mismatch_block (8), first_mismatch_index (10), first_mismatch_expected (8) and first_mismatch_actual (8).
  - These capture the first data mismatch of a run and hold until the next start.
  - All reset to 0.
  - Length faults are not logged.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- Drive model holds pattern 01,02,…; BLOCK_COUNT=2, start → address writes block 00 then 01, command 8'h80 twice, 1024 read_data byte pulses plus 2 clear pulses, done=1, pass=1, mismatch_count=0.
- Byte 5 of block 1 corrupted to 8'hAA → mismatch_count=1, pass=0. With the macro: first_mismatch_block=1, index=5, expected=8'h06 (from (512+5+1) mod 256), actual=8'hAA.
- Model completes block 0 after only 511 bytes → mismatch_count=1, pass=0, and the run continues to block 1.
- read_interface_error asserted during block 1 → FAIL: done=1, pass=0, busy=0, no further strobes.
- reset asserted in the middle of a block → all outputs at reset values the next cycle; a fresh start reruns from block 0 with expected byte 8'h01.
- drive_busy held high for 100 cycles after start → no address strobe until it falls, then ADDR1 exactly 1 cycle later.

Source files
------------

// File: rtl/kfmmc_read_verify_sequencer_if.sv
// Byte-wide register bus between the read-verify sequencer (master) and the KFMMC drive (slave).
interface kfmmc_read_verify_sequencer_if;
  logic [7:0] data_bus;
  logic       write_block_address_1;
  logic       write_block_address_2;
  logic       write_block_address_3;
  logic       write_block_address_4;
  logic       write_command;
  logic       read_data;
  logic [7:0] read_data_byte;
  logic       drive_busy;
  logic       read_byte_interrupt;
  logic       read_completion_interrupt;
  logic       read_interface_error;

  modport master (
    output data_bus, write_block_address_1, write_block_address_2,
           write_block_address_3, write_block_address_4, write_command, read_data,
    input  read_data_byte, drive_busy, read_byte_interrupt,
           read_completion_interrupt, read_interface_error
  );

  modport slave (
    input  data_bus, write_block_address_1, write_block_address_2,
           write_block_address_3, write_block_address_4, write_command, read_data,
    output read_data_byte, drive_busy, read_byte_interrupt,
           read_completion_interrupt, read_interface_error
  );
endinterface

// File: rtl/kfmmc_read_verify_sequencer.sv
// Reads back BLOCK_COUNT blocks from the KFMMC drive and checks them against the incrementing write pattern.
// Optional first-mismatch capture ports: define KFMMC_READ_VERIFY_MISMATCH_LOG_EN.
module kfmmc_read_verify_sequencer #(
  parameter logic [7:0] BLOCK_COUNT  = 8'h02,
  parameter logic [7:0] PATTERN_SEED = 8'h01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  kfmmc_read_verify_sequencer_if.master bus,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mismatch_count,
  output logic [7:0]  current_block
`ifdef KFMMC_READ_VERIFY_MISMATCH_LOG_EN
  ,
  output logic        first_mismatch_valid,
  output logic [7:0]  first_mismatch_block,
  output logic [9:0]  first_mismatch_index,
  output logic [7:0]  first_mismatch_expected,
  output logic [7:0]  first_mismatch_actual
`endif
);

  localparam logic [9:0] BLOCK_BYTES   = 10'd512;
  localparam logic [7:0] READ_COMMAND  = 8'h80;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_READY,
    ST_ADDR1,
    ST_ADDR2,
    ST_ADDR3,
    ST_ADDR4,
    ST_START_READ,
    ST_WAIT_INTERRUPT,
    ST_ACCEPT_BYTE,
    ST_WAIT_DEASSERT,
    ST_CLEAR_COMPLETION,
    ST_WAIT_BUSY,
    ST_DONE,
    ST_FAIL
  } state_e;

  state_e     state;
  state_e     state_next;
  logic [9:0] byte_index;
  logic [7:0] expected_byte;
  logic       run_start;
  logic       last_block;
  logic       byte_mismatch;
  logic       length_fault;

  assign run_start     = start && (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);
  assign last_block    = (current_block + 8'd1) == BLOCK_COUNT;
  assign byte_mismatch = (state == ST_ACCEPT_BYTE) && (bus.read_data_byte != expected_byte);
  assign length_fault  = (state == ST_CLEAR_COMPLETION) && (byte_index != BLOCK_BYTES);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_next                = state;
    bus.data_bus              = 8'h00;
    bus.write_block_address_1 = 1'b0;
    bus.write_block_address_2 = 1'b0;
    bus.write_block_address_3 = 1'b0;
    bus.write_block_address_4 = 1'b0;
    bus.write_command         = 1'b0;
    bus.read_data             = 1'b0;

    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) state_next = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (!bus.drive_busy) state_next = ST_ADDR1;
      end
      ST_ADDR1: begin
        bus.data_bus              = current_block;
        bus.write_block_address_1 = 1'b1;
        state_next                = ST_ADDR2;
      end
      ST_ADDR2: begin
        bus.write_block_address_2 = 1'b1;
        state_next                = ST_ADDR3;
      end
      ST_ADDR3: begin
        bus.write_block_address_3 = 1'b1;
        state_next                = ST_ADDR4;
      end
      ST_ADDR4: begin
        bus.write_block_address_4 = 1'b1;
        state_next                = ST_START_READ;
      end
      ST_START_READ: begin
        bus.data_bus      = READ_COMMAND;
        bus.write_command = 1'b1;
        state_next        = ST_WAIT_INTERRUPT;
      end
      ST_WAIT_INTERRUPT: begin
        // Error outranks completion, and completion outranks a pending byte.
        if (bus.read_interface_error)           state_next = ST_FAIL;
        else if (bus.read_completion_interrupt) state_next = ST_CLEAR_COMPLETION;
        else if (bus.read_byte_interrupt)       state_next = ST_ACCEPT_BYTE;
      end
      ST_ACCEPT_BYTE: begin
        bus.read_data = 1'b1;
        state_next    = ST_WAIT_DEASSERT;
      end
      ST_WAIT_DEASSERT: begin
        if (!bus.read_byte_interrupt) state_next = ST_WAIT_INTERRUPT;
      end
      ST_CLEAR_COMPLETION: begin
        bus.read_data = 1'b1;
        state_next    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!bus.drive_busy) state_next = last_block ? ST_DONE : ST_WAIT_READY;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = !(state == ST_IDLE || state == ST_DONE || state == ST_FAIL);
  assign done = (state == ST_DONE) || (state == ST_FAIL);
  assign pass = (state == ST_DONE) && (mismatch_count == 16'h0000);

  // The expected pattern runs on across blocks; only a new run reseeds it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      current_block  <= 8'h00;
      byte_index     <= 10'd0;
      expected_byte  <= PATTERN_SEED;
      mismatch_count <= 16'h0000;
    end else if (run_start) begin
      current_block  <= 8'h00;
      byte_index     <= 10'd0;
      expected_byte  <= PATTERN_SEED;
      mismatch_count <= 16'h0000;
    end else begin
      if (state == ST_ACCEPT_BYTE) begin
        expected_byte <= expected_byte + 8'd1;
        byte_index    <= byte_index + 10'd1;
      end
      if (state == ST_CLEAR_COMPLETION) begin
        byte_index <= 10'd0;
      end
      if ((byte_mismatch || length_fault) && (mismatch_count != 16'hFFFF)) begin
        mismatch_count <= mismatch_count + 16'd1;
      end
      if (state == ST_WAIT_BUSY && !bus.drive_busy && !last_block) begin
        current_block <= current_block + 8'd1;
      end
    end
  end

`ifdef KFMMC_READ_VERIFY_MISMATCH_LOG_EN
  // Only data mismatches are logged; length faults leave the capture untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_mismatch_valid    <= 1'b0;
      first_mismatch_block    <= 8'h00;
      first_mismatch_index    <= 10'd0;
      first_mismatch_expected <= 8'h00;
      first_mismatch_actual   <= 8'h00;
    end else if (run_start) begin
      first_mismatch_valid    <= 1'b0;
      first_mismatch_block    <= 8'h00;
      first_mismatch_index    <= 10'd0;
      first_mismatch_expected <= 8'h00;
      first_mismatch_actual   <= 8'h00;
    end else if (byte_mismatch && !first_mismatch_valid) begin
      first_mismatch_valid    <= 1'b1;
      first_mismatch_block    <= current_block;
      first_mismatch_index    <= byte_index;
      first_mismatch_expected <= expected_byte;
      first_mismatch_actual   <= bus.read_data_byte;
    end
  end
`endif

endmodule

// File: tb/tb_kfmmc_read_verify_sequencer.sv
// Scoreboard bench for kfmmc_read_verify_sequencer: a drive model streams the pattern, a reference model predicts strobes and results.
module tb_kfmmc_read_verify_sequencer;

  localparam logic [7:0] BLOCK_COUNT  = 8'h02;
  localparam logic [7:0] PATTERN_SEED = 8'h01;
  localparam int         BLOCK_BYTES  = 512;
  localparam int         NO_BLOCK     = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] mismatch_count;
  logic [7:0]  current_block;
`ifdef KFMMC_READ_VERIFY_MISMATCH_LOG_EN
  logic        first_mismatch_valid;
  logic [7:0]  first_mismatch_block;
  logic [9:0]  first_mismatch_index;
  logic [7:0]  first_mismatch_expected;
  logic [7:0]  first_mismatch_actual;
`endif
  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;

  kfmmc_read_verify_sequencer_if bus ();
  assign bus.drive_busy = model_busy | hold_busy;

  kfmmc_read_verify_sequencer #(
    .BLOCK_COUNT  (BLOCK_COUNT),
    .PATTERN_SEED (PATTERN_SEED)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_count (mismatch_count),
    .current_block  (current_block)
`ifdef KFMMC_READ_VERIFY_MISMATCH_LOG_EN
    ,
    .first_mismatch_valid    (first_mismatch_valid),
    .first_mismatch_block    (first_mismatch_block),
    .first_mismatch_index    (first_mismatch_index),
    .first_mismatch_expected (first_mismatch_expected),
    .first_mismatch_actual   (first_mismatch_actual)
`endif
  );

  always #5 clock = ~clock;

  typedef enum int {EV_ADDR1, EV_ADDR2, EV_ADDR3, EV_ADDR4, EV_CMD, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int data;
    int pass;
    int mm;
    int pulses;
    int blk;
    int log_valid;
    int log_blk;
    int log_idx;
    int log_exp;
    int log_act;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  mon_pulses = 0;

  // Scenario knobs, written by the stimulus process between runs.
  int         short_blk = NO_BLOCK;
  int         err_blk   = NO_BLOCK;
  int         err_pos   = 0;
  int         cor_blk   = NO_BLOCK;
  int         cor_idx   = 0;
  logic [7:0] cor_val   = 8'h00;
  bit         spurious  = 1'b0;
  int         gap_max   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic void push_strobe(input ev_kind_e k, input int d);
    ev_t ev;
    ev.kind = k;
    ev.data = d;
    exp_q.push_back(ev);
  endfunction

  // Reference model: walk the blocks the drive will deliver and count faults arithmetically.
  task automatic predict_run();
    ev_t ev;
    int g, mm, pulses, last, n, n_del, want, got;
    bit failed;
    g = 0; mm = 0; pulses = 0; last = 0; failed = 1'b0;
    ev.log_valid = 0;
    for (int b = 0; b < int'(BLOCK_COUNT); b++) begin
      last = b;
      push_strobe(EV_ADDR1, b);
      push_strobe(EV_ADDR2, 0);
      push_strobe(EV_ADDR3, 0);
      push_strobe(EV_ADDR4, 0);
      push_strobe(EV_CMD, 'h80);
      n     = (b == short_blk) ? BLOCK_BYTES - 1 : BLOCK_BYTES;
      n_del = (b == err_blk) ? err_pos : n;
      for (int k = 0; k < n_del; k++) begin
        want = (int'(PATTERN_SEED) + g) % 256;
        got  = (b == cor_blk && k == cor_idx) ? int'(cor_val) : want;
        if (got != want) begin
          mm++;
          if (ev.log_valid == 0) begin
            ev.log_valid = 1; ev.log_blk = b; ev.log_idx = k; ev.log_exp = want; ev.log_act = got;
          end
        end
        g++;
        pulses++;
      end
      if (b == err_blk) begin
        failed = 1'b1;
        break;
      end
      pulses++;
      if (n != BLOCK_BYTES) mm++;
    end
    ev.kind   = EV_DONE;
    ev.data   = 0;
    ev.pass   = (!failed && mm == 0) ? 1 : 0;
    ev.mm     = mm;
    ev.pulses = pulses;
    ev.blk    = last;
    exp_q.push_back(ev);
  endtask

  task automatic configure(input int s_blk, input int e_blk, input int e_pos, input int c_blk,
                           input int c_idx, input logic [7:0] c_val, input bit spur, input int gmax);
    short_blk = s_blk; err_blk = e_blk; err_pos = e_pos; cor_blk = c_blk;
    cor_idx = c_idx; cor_val = c_val; spurious = spur; gap_max = gmax;
  endtask

  function automatic int strobe_count();
    return int'(bus.write_block_address_1) + int'(bus.write_block_address_2) +
           int'(bus.write_block_address_3) + int'(bus.write_block_address_4) +
           int'(bus.write_command) + int'(bus.read_data);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_strobes"}, strobe_count(), 0);
    check({tag, "_data_bus"}, bus.data_bus, 8'h00);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_mismatch_count"}, mismatch_count, 0);
    check({tag, "_current_block"}, current_block, 0);
`ifdef KFMMC_READ_VERIFY_MISMATCH_LOG_EN
    check({tag, "_log_valid"}, first_mismatch_valid, 0);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_done_in_budget"}, done, 1);
    @(negedge clock);
    if (!done) begin
      apply_reset();
      @(negedge clock);
      reset = 1'b0;
    end
  endtask

  // Drive model: streams seed+n continuously across blocks, one byte per interrupt handshake.
  initial begin : drive_model
    int blk, pos, stream, gap, busy_cnt, limit;
    bit active;
    blk = 0; pos = 0; stream = 0; gap = 0; busy_cnt = 0; active = 1'b0;
    bus.read_data_byte            = 8'h00;
    bus.read_byte_interrupt       = 1'b0;
    bus.read_completion_interrupt = 1'b0;
    bus.read_interface_error      = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        bus.read_byte_interrupt       = 1'b0;
        bus.read_completion_interrupt = 1'b0;
        bus.read_interface_error      = 1'b0;
        active = 1'b0; stream = 0; busy_cnt = 0; model_busy = 1'b0;
      end else begin
        if (busy_cnt > 0) busy_cnt--;
        model_busy = (busy_cnt > 0);
        if (bus.write_block_address_1) begin
          blk = int'(bus.data_bus);
          if (blk == 0) stream = 0;
          active = 1'b0;
          bus.read_byte_interrupt       = 1'b0;
          bus.read_completion_interrupt = 1'b0;
          bus.read_interface_error      = 1'b0;
        end else if (bus.write_command) begin
          active = 1'b1;
          pos    = 0;
          gap    = 1 + int'($urandom_range(0, gap_max));
        end else if (active) begin
          limit = (blk == short_blk) ? BLOCK_BYTES - 1 : BLOCK_BYTES;
          if (bus.read_data) begin
            if (bus.read_completion_interrupt) begin
              bus.read_completion_interrupt = 1'b0;
              bus.read_byte_interrupt       = 1'b0;
              active     = 1'b0;
              busy_cnt   = int'($urandom_range(0, 3));
              model_busy = (busy_cnt > 0);
            end else if (bus.read_byte_interrupt) begin
              bus.read_byte_interrupt = 1'b0;
              pos++;
              stream++;
              gap = 1 + int'($urandom_range(0, gap_max));
            end
          end else if (!bus.read_byte_interrupt && !bus.read_completion_interrupt &&
                       !bus.read_interface_error) begin
            if (gap > 0) begin
              gap--;
            end else if (blk == err_blk && pos == err_pos) begin
              bus.read_interface_error = 1'b1;
              bus.read_byte_interrupt  = 1'b1;
            end else if (pos < limit) begin
              bus.read_data_byte = (blk == cor_blk && pos == cor_idx) ?
                                   cor_val : 8'(int'(PATTERN_SEED) + stream);
              bus.read_byte_interrupt = 1'b1;
            end else begin
              bus.read_completion_interrupt = 1'b1;
              if (spurious) bus.read_byte_interrupt = 1'b1;
            end
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe and on each rising done.
  initial begin : monitor
    bit rd_q, done_q, busy_q;
    int cyc, last_strobe, n_str, d;
    ev_kind_e k;
    ev_t e;
    rd_q = 1'b0; done_q = 1'b0; busy_q = 1'b0; cyc = 0; last_strobe = -100;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        rd_q = 1'b0; done_q = 1'b0; busy_q = 1'b0; mon_pulses = 0; last_strobe = -100;
      end else begin
        if (busy && !busy_q) mon_pulses = 0;
        if (bus.read_data) begin
          check("read_data_single_cycle", rd_q, 0);
          mon_pulses++;
        end
        n_str = strobe_count() - int'(bus.read_data);
        if (n_str != 0) begin
          check("strobe_onehot", n_str, 1);
          k = bus.write_block_address_1 ? EV_ADDR1 :
              bus.write_block_address_2 ? EV_ADDR2 :
              bus.write_block_address_3 ? EV_ADDR3 :
              bus.write_block_address_4 ? EV_ADDR4 : EV_CMD;
          d = int'(bus.data_bus);
          if (exp_q.size() == 0) begin
            check("strobe_expected", n_str, 0);
          end else begin
            e = exp_q.pop_front();
            check("strobe_kind", k, e.kind);
            check("strobe_data", d, e.data);
            if (k != EV_ADDR1) check("strobe_consecutive", cyc - last_strobe, 1);
          end
          last_strobe = cyc;
        end
        if (done && !done_q) begin
          if (exp_q.size() == 0) begin
            check("done_expected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("done_kind", k == EV_DONE ? EV_DONE : e.kind, EV_DONE);
            check("done_pass", pass, e.pass);
            check("done_mismatch_count", mismatch_count, e.mm);
            check("done_read_data_pulses", mon_pulses, e.pulses);
            check("done_current_block", current_block, e.blk);
            check("done_busy", busy, 0);
`ifdef KFMMC_READ_VERIFY_MISMATCH_LOG_EN
            check("log_valid", first_mismatch_valid, e.log_valid);
            if (e.log_valid != 0) begin
              check("log_block", first_mismatch_block, e.log_blk);
              check("log_index", first_mismatch_index, e.log_idx);
              check("log_expected", first_mismatch_expected, e.log_exp);
              check("log_actual", first_mismatch_actual, e.log_act);
            end
`endif
          end
        end
        rd_q   = bus.read_data;
        done_q = done;
        busy_q = busy;
      end
    end
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation did not complete, n_total=%0d", n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int lat, n;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Clean run, also timing start to first address strobe.
    configure(NO_BLOCK, NO_BLOCK, 0, NO_BLOCK, 0, 8'h00, 1'b0, 0);
    predict_run();
    pulse_start();
    lat = 1;
    while (!bus.write_block_address_1 && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check("start_to_addr1_cycles", lat, 2);
    wait_done(20000, "clean");

    // Byte 5 of block 1 corrupted; restart straight from DONE.
    configure(NO_BLOCK, NO_BLOCK, 0, 1, 5, 8'hAA, 1'b0, 0);
    predict_run();
    pulse_start();
    wait_done(20000, "corrupt");

    // Block 0 ends one byte short.
    configure(0, NO_BLOCK, 0, NO_BLOCK, 0, 8'h00, 1'b0, 0);
    predict_run();
    pulse_start();
    wait_done(20000, "short");

    // Interface error in block 1, raised together with a byte interrupt.
    configure(NO_BLOCK, 1, 100, NO_BLOCK, 0, 8'h00, 1'b0, 0);
    predict_run();
    pulse_start();
    wait_done(20000, "error");
    n = 0;
    repeat (40) begin
      @(negedge clock);
      n += strobe_count();
    end
    check("strobes_after_fail", n, 0);
    check("fail_done_held", done, 1);
    check("fail_pass", pass, 0);
    check("fail_busy", busy, 0);

    // Reset in the middle of block 0, started from FAIL.
    configure(NO_BLOCK, NO_BLOCK, 0, NO_BLOCK, 0, 8'h00, 1'b0, 1);
    predict_run();
    pulse_start();
    n = 0;
    while (mon_pulses < 60 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("reached_mid_block", mon_pulses >= 60, 1);
    apply_reset();
    check_reset_values("mid_run_reset");
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clock);
      n += strobe_count();
    end
    check("strobes_after_reset", n, 0);

    // Fresh run after reset, completion arriving together with a byte interrupt.
    configure(NO_BLOCK, NO_BLOCK, 0, NO_BLOCK, 0, 8'h00, 1'b1, 1);
    predict_run();
    pulse_start();
    wait_done(20000, "after_reset");

    // drive_busy held for 100 cycles: ADDR1 follows its fall by exactly one cycle.
    configure(NO_BLOCK, NO_BLOCK, 0, NO_BLOCK, 0, 8'h00, 1'b0, 0);
    hold_busy = 1'b1;
    predict_run();
    pulse_start();
    n = 0;
    repeat (100) begin
      @(negedge clock);
      n += strobe_count();
    end
    check("strobes_while_busy", n, 0);
    hold_busy = 1'b0;
    check("addr1_at_busy_fall", bus.write_block_address_1, 0);
    @(negedge clock);
    check("addr1_one_cycle_after_busy", bus.write_block_address_1, 1);
    wait_done(20000, "busy_hold");

    // Randomised runs.
    for (int r = 0; r < 2; r++) begin
      configure(($urandom_range(0, 1) == 0) ? 0 : NO_BLOCK, NO_BLOCK, 0,
                int'($urandom_range(0, 1)), int'($urandom_range(0, 511)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1);
      predict_run();
      pulse_start();
      wait_done(20000, "random");
    end

    repeat (5) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
